mux21_arbiter: RTL and testbench
================================

// Module: mux21_arbiter
// PURPOSE
//  Round-robin arbiter/controller that shares one MUX21 (2:1 mux, Y = S ? B : A) between two requesters.
//  Grants ownership to requester A or B, drives the mux select S, and preempts a long-running owner.
//  Sits directly in front of the MUX21 select input; requester data goes straight to mux inputs A/B.
// PARAMETERS
//  MAX_HOLD   16  max consecutive owned cycles before preemption if the other side is waiting; 0 = never preempt
//  CNT_W      16  width of statistics counters (used only with MUX21_ARB_STATS_EN)
// PORTS
//  CLK          in   1      clock, all logic on rising edge
//  RST          in   1      synchronous, active-high reset
//  REQ_A        in   1      requester A wants the mux; held high for whole transfer
//  REQ_B        in   1      requester B wants the mux; held high for whole transfer
//  GNT_A        out  1      A owns mux (registered)
//  GNT_B        out  1      B owns mux (registered)
//  S            out  1      MUX21 select: 0 = A routed to Y, 1 = B routed to Y (registered)
//  BUSY         out  1      mux owned by someone (GNT_A | GNT_B)
//  PREEMPT      out  1      1-cycle pulse, cycle after a forced handover
//  GRANT_CNT_A  out  CNT_W  grants issued to A (MUX21_ARB_STATS_EN only)
//  GRANT_CNT_B  out  CNT_W  grants issued to B (MUX21_ARB_STATS_EN only)
// BEHAVIOUR
//  - Reset: state=IDLE, GNT_A=0, GNT_B=0, S=0, BUSY=0, PREEMPT=0, hold_cnt=0, last=B (A wins first tie).
//  - States: IDLE, OWN_A, OWN_B. Outputs decoded from registered state; no combinational REQ->GNT path.
//  - Latency: REQ sampled at edge N -> GNT/S valid after edge N (visible cycle N+1). 1 cycle.
//  - IDLE: REQ_A&~REQ_B -> OWN_A; ~REQ_A&REQ_B -> OWN_B; both -> side != last; none -> stay.
//  - OWN_A: S=0, GNT_A=1. REQ_A=0 -> OWN_B if REQ_B else IDLE (no idle bubble on handover).
//    REQ_A=1, REQ_B=1, hold_cnt==MAX_HOLD-1 (MAX_HOLD!=0) -> OWN_B, PREEMPT pulses.
//    REQ_A=1, REQ_B=0 -> stay; hold_cnt saturates at MAX_HOLD-1 (no wrap).
//  - OWN_B: mirror of OWN_A with S=1.
//  - hold_cnt: clears to 0 on every entry to OWN_A/OWN_B; +1 per owned cycle; width $clog2(MAX_HOLD+1) min 1.
//  - last: updated to the granted side on every entry to OWN_A/OWN_B.
//  - S holds its last value in IDLE (no glitch on mux output while idle).
//  - GNT_A and GNT_B never both 1; handover A->B is a single-cycle switch (GNT_A falls, GNT_B rises same edge).
//  - Requester drops REQ same cycle preempt fires: normal release path wins, PREEMPT stays 0.
//  - RST mid-ownership: next cycle all outputs at reset values, grant lost; requester must hold REQ to regain.
//  - MAX_HOLD=1: with both requesting, grant alternates every cycle.
// CONFIGURATION
//  MUX21_ARB_STATS_EN defined: GRANT_CNT_A/B ports exist; each +1 on entry to its OWN state
//    (incl. preempt/handover), saturate at all-ones, clear on RST.
//  MUX21_ARB_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 RST=1 two cycles, REQ_A=REQ_B=0 -> GNT_A=GNT_B=0, S=0, BUSY=0, PREEMPT=0.
//  2 REQ_A=1 only, 5 cycles, then 0 -> GNT_A=1/S=0 from cycle after REQ; IDLE and GNT_A=0 cycle after drop.
//  3 REQ_A,REQ_B rise same cycle after reset -> GNT_A first (last=B); A drops -> GNT_B next edge, S=1, no bubble.
//  4 MAX_HOLD=4, REQ_A held, REQ_B raised -> GNT_A 4 cycles, then GNT_B, S=1, PREEMPT=1 one cycle.
//  5 OWN_B, RST pulsed 1 cycle with REQ_B held -> cycle after: GNT_B=0,S=0; next: GNT_B=1,S=1 again.
//  6 STATS_EN: 3 A grants + 2 B grants -> GRANT_CNT_A=3, GRANT_CNT_B=2; RST -> both 0.

Source files
------------

// File: rtl/mux21_arbiter.sv
// mux21_arbiter: round-robin owner of a shared 2:1 mux (Y = S ? B : A).
// Grants A or B, drives the mux select S, and forces a handover when the
// current owner has held the mux for MAX_HOLD cycles while the other side waits.
// Optional statistics counters are enabled by defining MUX21_ARB_STATS_EN.
module mux21_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_A,
    input  logic             REQ_B,
    output logic             GNT_A,
    output logic             GNT_B,
    output logic             S,
    output logic             BUSY,
    output logic             PREEMPT
`ifdef MUX21_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] GRANT_CNT_A,
    output logic [CNT_W-1:0] GRANT_CNT_B
`endif
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    // Last owned-cycle index before a waiting peer may take over; also the
    // saturation point of hold_cnt so it never wraps while nobody waits.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam bit PREEMPT_EN = (MAX_HOLD != 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              last_b;
    logic              s_q;
    logic              preempt_q;
    logic              force_nxt;
    logic              enter_a, enter_b;

    // Next-state: tie goes to the side that did not own last; a release
    // with the peer waiting hands over directly without an idle cycle.
    always_comb begin
        state_nxt = state;
        force_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (REQ_A && (!REQ_B || last_b)) state_nxt = ST_OWN_A;
                else if (REQ_B)                  state_nxt = ST_OWN_B;
            end
            ST_OWN_A: begin
                if (!REQ_A) begin
                    state_nxt = REQ_B ? ST_OWN_B : ST_IDLE;
                end else if (REQ_B && PREEMPT_EN && hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_OWN_B;
                    force_nxt = 1'b1;
                end
            end
            ST_OWN_B: begin
                if (!REQ_B) begin
                    state_nxt = REQ_A ? ST_OWN_A : ST_IDLE;
                end else if (REQ_A && PREEMPT_EN && hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_OWN_A;
                    force_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign enter_a = (state_nxt == ST_OWN_A) && (state != ST_OWN_A);
    assign enter_b = (state_nxt == ST_OWN_B) && (state != ST_OWN_B);

    // State, hold counter, fairness pointer and mux select; S only moves
    // on a new grant so the mux output stays quiet while idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            last_b    <= 1'b1;
            s_q       <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            preempt_q <= force_nxt;
            if (enter_a || enter_b)
                hold_cnt <= '0;
            else if (state_nxt != ST_IDLE && hold_cnt != HOLD_LAST)
                hold_cnt <= hold_cnt + HOLD_W'(1);
            if (enter_a) begin
                last_b <= 1'b0;
                s_q    <= 1'b0;
            end else if (enter_b) begin
                last_b <= 1'b1;
                s_q    <= 1'b1;
            end
        end
    end

    assign GNT_A   = (state == ST_OWN_A);
    assign GNT_B   = (state == ST_OWN_B);
    assign BUSY    = (state != ST_IDLE);
    assign S       = s_q;
    assign PREEMPT = preempt_q;

`ifdef MUX21_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_a, cnt_b;

    // Saturating grant counters, bumped on every entry to an owned state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (enter_a && cnt_a != '1) cnt_a <= cnt_a + CNT_W'(1);
            if (enter_b && cnt_b != '1) cnt_b <= cnt_b + CNT_W'(1);
        end
    end

    assign GRANT_CNT_A = cnt_a;
    assign GRANT_CNT_B = cnt_b;
`endif

endmodule

// File: tb/tb_mux21_arbiter.sv
// Bench for mux21_arbiter (MAX_HOLD=4). A behavioural reference pushes the
// expected registered outputs for every driven cycle; each scenario task pops
// and compares after the clock edge.
module tb_mux21_arbiter;

    localparam int MH = 4;
    localparam int CW = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic REQ_A = 1'b0;
    logic REQ_B = 1'b0;
    logic GNT_A, GNT_B, S, BUSY, PREEMPT;
`ifdef MUX21_ARB_STATS_EN
    logic [CW-1:0] GRANT_CNT_A, GRANT_CNT_B;
`endif

    always #5 CLK = ~CLK;

    mux21_arbiter #(.MAX_HOLD(MH), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .REQ_A(REQ_A), .REQ_B(REQ_B),
        .GNT_A(GNT_A), .GNT_B(GNT_B), .S(S), .BUSY(BUSY), .PREEMPT(PREEMPT)
`ifdef MUX21_ARB_STATS_EN
        , .GRANT_CNT_A(GRANT_CNT_A), .GRANT_CNT_B(GRANT_CNT_B)
`endif
    );

    // {gnt_a, gnt_b, s, busy, preempt}
    typedef logic [4:0] exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // reference state: 0 idle, 1 A owns, 2 B owns
    int   m_st = 0;
    int   m_hold = 0;
    logic m_last_b = 1'b1;
    logic m_s = 1'b0;
    logic m_pre = 1'b0;
    int   m_cnt_a = 0;
    int   m_cnt_b = 0;

    function automatic void model(input logic rst, input logic ra, input logic rb);
        int nxt;
        logic pre;
        if (rst) begin
            m_st = 0; m_hold = 0; m_last_b = 1'b1; m_s = 1'b0; m_pre = 1'b0;
            m_cnt_a = 0; m_cnt_b = 0;
        end else begin
            nxt = m_st;
            pre = 1'b0;
            if (m_st == 0) begin
                if (ra && rb) nxt = m_last_b ? 1 : 2;
                else if (ra)  nxt = 1;
                else if (rb)  nxt = 2;
            end else begin
                logic mine, other;
                mine  = (m_st == 1) ? ra : rb;
                other = (m_st == 1) ? rb : ra;
                if (!mine)
                    nxt = other ? 3 - m_st : 0;
                else if (other && m_hold >= MH - 1) begin
                    nxt = 3 - m_st;
                    pre = 1'b1;
                end
            end
            if (nxt != 0 && nxt != m_st) begin
                m_hold   = 0;
                m_last_b = (nxt == 2);
                m_s      = (nxt == 2);
                if (nxt == 1 && m_cnt_a < 65535) m_cnt_a++;
                if (nxt == 2 && m_cnt_b < 65535) m_cnt_b++;
            end else if (nxt != 0 && m_hold < MH - 1) begin
                m_hold++;
            end
            m_st  = nxt;
            m_pre = pre;
        end
        sb.push_back({m_st == 1, m_st == 2, m_s, m_st != 0, m_pre});
    endfunction

    // drive one cycle of stimulus, record the expectation, wait until after the edge
    task automatic drive(input logic rst, input logic ra, input logic rb);
        RST = rst; REQ_A = ra; REQ_B = rb;
        model(rst, ra, rb);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            e = sb.pop_front();
            o = {GNT_A, GNT_B, S, BUSY, PREEMPT};
            n_cmp++;
            if (o !== e || o !== 5'b00000) begin
                n_err++;
                $display("FAIL reset[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_single_a();
        exp_t e, o;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, i < 5, 1'b0);
            e = sb.pop_front();
            o = {GNT_A, GNT_B, S, BUSY, PREEMPT};
            n_cmp++;
            if (o !== e || o !== ((i < 5) ? 5'b10010 : 5'b00000)) begin
                n_err++;
                $display("FAIL single_a[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_tie_handover();
        exp_t e, o;
        drive(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        // both rise together: A first, A drops after 2 cycles, B takes over
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, i < 2, i < 4);
            e = sb.pop_front();
            o = {GNT_A, GNT_B, S, BUSY, PREEMPT};
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL tie_handover[%0d]: got %b want %b", i, o, e);
            end
            if (i == 0 || i == 2) begin
                n_cmp++;
                if (o !== ((i == 0) ? 5'b10010 : 5'b01110)) begin
                    n_err++;
                    $display("FAIL tie_order[%0d]: got %b", i, o);
                end
            end
        end
    endtask

    task automatic test_preempt();
        exp_t e, o;
        int npre;
        drive(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        npre = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, i > 0);
            e = sb.pop_front();
            o = {GNT_A, GNT_B, S, BUSY, PREEMPT};
            npre += PREEMPT;
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL preempt[%0d]: got %b want %b", i, o, e);
            end
            if (i == 3 || i == 4) begin
                n_cmp++;
                if (o !== ((i == 3) ? 5'b10010 : 5'b01111)) begin
                    n_err++;
                    $display("FAIL preempt_edge[%0d]: got %b", i, o);
                end
            end
        end
        n_cmp++;
        if (npre !== 1) begin
            n_err++;
            $display("FAIL preempt_count: got %0d want 1", npre);
        end
        drive(1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
    endtask

    task automatic test_drop_on_preempt();
        exp_t e, o;
        drive(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        // A releases on exactly the cycle its hold expires: plain handover
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, i < 4, i > 0);
            e = sb.pop_front();
            o = {GNT_A, GNT_B, S, BUSY, PREEMPT};
            n_cmp++;
            if (o !== e || (i == 4 && o !== 5'b01110)) begin
                n_err++;
                $display("FAIL drop_on_preempt[%0d]: got %b want %b", i, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        logic [2:0] rst_seq;
        rst_seq = 3'b100;
        for (int i = 0; i < 4; i++) begin
            drive(i == 2, 1'b0, 1'b1);
            e = sb.pop_front();
            o = {GNT_A, GNT_B, S, BUSY, PREEMPT};
            n_cmp++;
            if (o !== e || (i == 2 && o !== 5'b00000) || (i == 3 && o !== 5'b01110)) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: got %b want %b", i, o, e);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
    endtask

    task automatic test_random();
        exp_t e, o;
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            e = sb.pop_front();
            o = {GNT_A, GNT_B, S, BUSY, PREEMPT};
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL random[%0d]: got %b want %b", i, o, e);
            end
`ifdef MUX21_ARB_STATS_EN
            n_cmp++;
            if (GRANT_CNT_A !== CW'(m_cnt_a) || GRANT_CNT_B !== CW'(m_cnt_b)) begin
                n_err++;
                $display("FAIL random_cnt[%0d]: got %0d/%0d want %0d/%0d",
                         i, GRANT_CNT_A, GRANT_CNT_B, m_cnt_a, m_cnt_b);
            end
`endif
        end
    endtask

`ifdef MUX21_ARB_STATS_EN
    task automatic test_stats();
        drive(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        // three separate A grants, two separate B grants, idle between
        for (int g = 0; g < 5; g++) begin
            drive(1'b0, g < 3, g >= 3);
            void'(sb.pop_front());
            drive(1'b0, 1'b0, 1'b0);
            void'(sb.pop_front());
        end
        n_cmp++;
        if (GRANT_CNT_A !== 16'd3 || GRANT_CNT_B !== 16'd2) begin
            n_err++;
            $display("FAIL stats_count: got %0d/%0d want 3/2", GRANT_CNT_A, GRANT_CNT_B);
        end
        drive(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        n_cmp++;
        if (GRANT_CNT_A !== 16'd0 || GRANT_CNT_B !== 16'd0) begin
            n_err++;
            $display("FAIL stats_reset: got %0d/%0d want 0/0", GRANT_CNT_A, GRANT_CNT_B);
        end
    endtask
`endif

    // Mutual exclusion and BUSY consistency checked every cycle.
    always @(negedge CLK) begin
        if (!RST) begin
            n_cmp++;
            if ((GNT_A && GNT_B) || BUSY !== (GNT_A | GNT_B)) begin
                n_err++;
                $display("FAIL exclusive: gnt_a=%b gnt_b=%b busy=%b", GNT_A, GNT_B, BUSY);
            end
        end
    end

    initial begin
        test_reset();
        test_single_a();
        test_tie_handover();
        test_preempt();
        test_drop_on_preempt();
        test_reset_mid();
`ifdef MUX21_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
